// File: rtl/lane_follow_pkg.sv
// rtl/lane_follow_pkg.sv - shared types and helpers for the lane follow monitor
// Contents: lf_state_e checker state, lf_timer_w() latency timer width,
//           sat_inc() saturating counter increment.
package lane_follow_pkg;

    typedef enum logic [1:0] {
        LF_IDLE = 2'd0,
        LF_WAIT = 2'd1,
        LF_OFF  = 2'd2
    } lf_state_e;

    // Width needed to hold 0..max_lat, never less than one bit.
    function automatic int lf_timer_w(input int max_lat);
        int w;
        w = $clog2(max_lat + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Increment a w-bit counter, holding at all-ones instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int w);
        logic [63:0] max_v;
        max_v = (64'd1 << w) - 64'd1;
        return (cnt >= max_v) ? max_v : cnt + 64'd1;
    endfunction

endpackage

// File: rtl/lane_follow_monitor_if.sv
// rtl/lane_follow_monitor_if.sv - tapped lane buses between lane driver and monitor
// Signals: lane_inputs / lane_outputs [LANES]
// Modports: master (lane mux/driver side), slave (monitor side, observe only)
interface lane_follow_monitor_if #(
    parameter int LANES = 8
);
    logic [LANES-1:0] lane_inputs;
    logic [LANES-1:0] lane_outputs;

    modport master (output lane_inputs, output lane_outputs);
    modport slave  (input  lane_inputs, input  lane_outputs);
endinterface

// File: rtl/lane_chg_det.sv
// rtl/lane_chg_det.sv - registered previous-value change detector
// Ports: clk, rst_n (async, active low), d [W] sampled bus, chg bus differs from last cycle
module lane_chg_det #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic         chg
);

    logic [W-1:0] q;
    logic         primed;

    // q tracks the bus every cycle; primed masks the first cycle after
    // reset so the cleared q is never compared against live data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            primed <= 1'b0;
        end else begin
            q      <= d;
            primed <= 1'b1;
        end
    end

    assign chg = primed && (d != q);

endmodule

// File: rtl/lane_follow_monitor.sv
// rtl/lane_follow_monitor.sv - run-time check that lane input changes are followed by lane output changes
// Ports: clk, rst_n (async, active low), ana_byp check enable, lanes (slave modport),
//        clr counter clear, pending, err_pulse, pass_cnt [CNT_W], err_cnt [CNT_W]
// Macro LANE_FOLLOW_CAPTURE_EN adds err_snap [2*LANES] and snap_vld (first-violation capture).
module lane_follow_monitor
    import lane_follow_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int MAX_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ana_byp,
    lane_follow_monitor_if.slave   lanes,
    input  logic                   clr,
    output logic                   pending,
    output logic                   err_pulse,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       err_cnt
`ifdef LANE_FOLLOW_CAPTURE_EN
    ,
    output logic [2*LANES-1:0]     err_snap,
    output logic                   snap_vld
`endif
);

    localparam int            TW       = lf_timer_w(MAX_LAT);
    localparam logic [TW-1:0] TMR_LOAD = TW'(MAX_LAT);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    logic [LANES-1:0] lane_in;
    logic [LANES-1:0] lane_out;
    logic             in_chg;
    logic             out_chg;

    lf_state_e        state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic             pass_now;
    logic             err_now;

    assign lane_in  = lanes.lane_inputs;
    assign lane_out = lanes.lane_outputs;

    lane_chg_det #(.W(LANES)) u_in_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lane_in),
        .chg   (in_chg)
    );

    lane_chg_det #(.W(LANES)) u_out_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lane_out),
        .chg   (out_chg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LF_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // OFF behaves like IDLE once ana_byp returns: the change detectors kept
    // tracking while disabled, so there is no stale history to flush.
    always_comb begin
        state_nxt = state;
        if (!ana_byp) begin
            state_nxt = LF_OFF;
        end else begin
            case (state)
                LF_IDLE, LF_OFF: begin
                    if (in_chg && !out_chg && (MAX_LAT > 0))
                        state_nxt = LF_WAIT;
                    else
                        state_nxt = LF_IDLE;
                end
                LF_WAIT: begin
                    if (out_chg)
                        state_nxt = LF_IDLE;
                    else if (in_chg)
                        state_nxt = LF_WAIT;
                    else if (timer == TMR_ONE)
                        state_nxt = LF_IDLE;
                    else
                        state_nxt = LF_WAIT;
                end
                default: state_nxt = LF_IDLE;
            endcase
        end
    end

    // timer holds the cycles of the window still left after the current one;
    // a WAIT cycle with timer==1 and no output change is the last chance,
    // so the violation is decided there and the count would reach 0.
    always_comb begin
        pass_now  = 1'b0;
        err_now   = 1'b0;
        timer_nxt = timer;
        if (ana_byp) begin
            case (state)
                LF_IDLE, LF_OFF: begin
                    if (in_chg) begin
                        if (out_chg)
                            pass_now = 1'b1;
                        else if (MAX_LAT == 0)
                            err_now = 1'b1;
                        else
                            timer_nxt = TMR_LOAD;
                    end
                end
                LF_WAIT: begin
                    if (out_chg)
                        pass_now = 1'b1;
                    else if (in_chg)
                        timer_nxt = TMR_LOAD;
                    else if (timer == TMR_ONE)
                        err_now = 1'b1;
                    else
                        timer_nxt = timer - TMR_ONE;
                end
                default: ;
            endcase
        end
    end

    assign pending = (state == LF_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            pass_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= err_now;
            if (clr) begin
                pass_cnt <= '0;
                err_cnt  <= '0;
            end else begin
                if (pass_now)
                    pass_cnt <= CNT_W'(sat_inc(64'(pass_cnt), CNT_W));
                if (err_now)
                    err_cnt  <= CNT_W'(sat_inc(64'(err_cnt), CNT_W));
            end
        end
    end

`ifdef LANE_FOLLOW_CAPTURE_EN
    logic [LANES-1:0] trig_q;

    // trig_q keeps the input value of the latest unanswered change. On an
    // error the outputs did not change that cycle, so lane_out equals out_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q   <= '0;
            err_snap <= '0;
            snap_vld <= 1'b0;
        end else begin
            if (ana_byp && in_chg && !out_chg)
                trig_q <= lane_in;
            if (clr) begin
                snap_vld <= 1'b0;
            end else if (err_now && !snap_vld) begin
                snap_vld <= 1'b1;
                err_snap <= {((state == LF_WAIT) ? trig_q : lane_in), lane_out};
            end
        end
    end
`endif

endmodule

// File: tb/tb_lane_follow_monitor.sv
// tb/tb_lane_follow_monitor.sv - directed self-checking bench for lane_follow_monitor (LANE_FOLLOW_CAPTURE_EN aware)
module tb_lane_follow_monitor;

    logic clk;
    logic rst_n;

    logic        ana_byp, clr, pending, err_pulse;
    logic [15:0] pass_cnt, err_cnt;
    logic        ana_byp2, clr2, pending2, err_pulse2;
    logic [1:0]  pass_cnt2, err_cnt2;
`ifdef LANE_FOLLOW_CAPTURE_EN
    logic [15:0] err_snap, err_snap2;
    logic        snap_vld, snap_vld2;
`endif

    int n_cmp;
    int n_bad;

    lane_follow_monitor_if #(.LANES(8)) l1 ();
    lane_follow_monitor_if #(.LANES(8)) l2 ();

    lane_follow_monitor #(.LANES(8), .MAX_LAT(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ana_byp   (ana_byp),
        .lanes     (l1),
        .clr       (clr),
        .pending   (pending),
        .err_pulse (err_pulse),
        .pass_cnt  (pass_cnt),
        .err_cnt   (err_cnt)
`ifdef LANE_FOLLOW_CAPTURE_EN
        ,
        .err_snap  (err_snap),
        .snap_vld  (snap_vld)
`endif
    );

    lane_follow_monitor #(.LANES(8), .MAX_LAT(0), .CNT_W(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ana_byp   (ana_byp2),
        .lanes     (l2),
        .clr       (clr2),
        .pending   (pending2),
        .err_pulse (err_pulse2),
        .pass_cnt  (pass_cnt2),
        .err_cnt   (err_cnt2)
`ifdef LANE_FOLLOW_CAPTURE_EN
        ,
        .err_snap  (err_snap2),
        .snap_vld  (snap_vld2)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL rst_pending got=%0b exp=0", pending); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_err_pulse got=%0b exp=0", err_pulse); end
        n_cmp++; if (pass_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_pass_cnt got=%0d exp=0", pass_cnt); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL prime_pending c%0d got=%0b exp=0", i, pending); end
            n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL prime_err_pulse c%0d got=%0b exp=0", i, err_pulse); end
        end
        n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL prime_err_cnt got=%0d exp=0", err_cnt); end
        n_cmp++; if (pass_cnt !== 16'd0) begin n_bad++; $display("FAIL prime_pass_cnt got=%0d exp=0", pass_cnt); end
    endtask

    task automatic test_bypass_resync();
        ana_byp = 1'b0;
        l1.lane_inputs = 8'h00;
        tick();
        tick();
        ana_byp = 1'b1;
        tick();
        tick();
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL resync_pending got=%0b exp=0", pending); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL resync_err_cnt got=%0d exp=0", err_cnt); end
        n_cmp++; if (pass_cnt !== 16'd0) begin n_bad++; $display("FAIL resync_pass_cnt got=%0d exp=0", pass_cnt); end
    endtask

    task automatic test_pass();
        l1.lane_inputs = 8'h01;
        tick();
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL pass_pending_hi got=%0b exp=1", pending); end
        l1.lane_outputs = 8'h01;
        tick();
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL pass_pending_lo got=%0b exp=0", pending); end
        n_cmp++; if (pass_cnt !== 16'd1) begin n_bad++; $display("FAIL pass_cnt1 got=%0d exp=1", pass_cnt); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL pass_err_cnt got=%0d exp=0", err_cnt); end
        tick();
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL pass_err_pulse got=%0b exp=0", err_pulse); end
    endtask

    task automatic test_same_cycle();
        l1.lane_inputs  = 8'h02;
        l1.lane_outputs = 8'h02;
        tick();
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL same_pending got=%0b exp=0", pending); end
        n_cmp++; if (pass_cnt !== 16'd2) begin n_bad++; $display("FAIL same_pass_cnt got=%0d exp=2", pass_cnt); end
    endtask

    task automatic test_timeout();
        l1.lane_inputs = 8'h03;
        tick();
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL to_pending_c11 got=%0b exp=1", pending); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse_c11 got=%0b exp=0", err_pulse); end
        tick();
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL to_pending_c12 got=%0b exp=1", pending); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse_c12 got=%0b exp=0", err_pulse); end
        tick();
        n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL to_err_pulse_c13 got=%0b exp=1", err_pulse); end
        n_cmp++; if (err_cnt !== 16'd1) begin n_bad++; $display("FAIL to_err_cnt got=%0d exp=1", err_cnt); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL to_pending_c13 got=%0b exp=0", pending); end
        n_cmp++; if (pass_cnt !== 16'd2) begin n_bad++; $display("FAIL to_pass_cnt got=%0d exp=2", pass_cnt); end
        tick();
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse_c14 got=%0b exp=0", err_pulse); end
    endtask

    task automatic test_retrigger();
        l1.lane_inputs = 8'h04;
        tick();
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL rt_pending_c11 got=%0b exp=1", pending); end
        l1.lane_inputs = 8'h05;
        tick();
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL rt_pending_c12 got=%0b exp=1", pending); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL rt_err_pulse_c12 got=%0b exp=0", err_pulse); end
        tick();
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL rt_pending_c13 got=%0b exp=1", pending); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL rt_err_pulse_c13 got=%0b exp=0", err_pulse); end
        l1.lane_outputs = 8'h04;
        tick();
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL rt_pending_c14 got=%0b exp=0", pending); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL rt_err_pulse_c14 got=%0b exp=0", err_pulse); end
        n_cmp++; if (pass_cnt !== 16'd3) begin n_bad++; $display("FAIL rt_pass_cnt got=%0d exp=3", pass_cnt); end
        n_cmp++; if (err_cnt !== 16'd1) begin n_bad++; $display("FAIL rt_err_cnt got=%0d exp=1", err_cnt); end
        tick();
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL rt_err_pulse_c15 got=%0b exp=0", err_pulse); end
    endtask

    task automatic test_abandon();
        l1.lane_inputs = 8'h06;
        tick();
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL ab_pending_c11 got=%0b exp=1", pending); end
        ana_byp = 1'b0;
        tick();
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL ab_pending_c12 got=%0b exp=0", pending); end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) l1.lane_inputs = 8'h07;
            tick();
            n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL ab_err_pulse c%0d got=%0b exp=0", i, err_pulse); end
            n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL ab_pending_off c%0d got=%0b exp=0", i, pending); end
        end
        ana_byp = 1'b1;
        tick();
        tick();
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL ab_pending_on got=%0b exp=0", pending); end
        n_cmp++; if (err_cnt !== 16'd1) begin n_bad++; $display("FAIL ab_err_cnt got=%0d exp=1", err_cnt); end
        n_cmp++; if (pass_cnt !== 16'd3) begin n_bad++; $display("FAIL ab_pass_cnt got=%0d exp=3", pass_cnt); end
    endtask

    task automatic test_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (pass_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_pass_cnt got=%0d exp=0", pass_cnt); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_err_cnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_saturate_lat0();
        l2.lane_inputs = 8'h01;
        tick();
        n_cmp++; if (err_pulse2 !== 1'b1) begin n_bad++; $display("FAIL sat_err_pulse1 got=%0b exp=1", err_pulse2); end
        n_cmp++; if (err_cnt2 !== 2'd1) begin n_bad++; $display("FAIL sat_err_cnt1 got=%0d exp=1", err_cnt2); end
        n_cmp++; if (pending2 !== 1'b0) begin n_bad++; $display("FAIL sat_pending got=%0b exp=0", pending2); end
`ifdef LANE_FOLLOW_CAPTURE_EN
        n_cmp++; if (snap_vld2 !== 1'b1) begin n_bad++; $display("FAIL snap_vld1 got=%0b exp=1", snap_vld2); end
        n_cmp++; if (err_snap2 !== 16'h0100) begin n_bad++; $display("FAIL snap_first got=%h exp=0100", err_snap2); end
`endif
        l2.lane_inputs = 8'h02;
        tick();
        l2.lane_inputs = 8'h03;
        tick();
        n_cmp++; if (err_cnt2 !== 2'd3) begin n_bad++; $display("FAIL sat_err_cnt3 got=%0d exp=3", err_cnt2); end
        l2.lane_inputs = 8'h04;
        tick();
        l2.lane_inputs = 8'h05;
        tick();
        n_cmp++; if (err_cnt2 !== 2'd3) begin n_bad++; $display("FAIL sat_err_cnt5 got=%0d exp=3", err_cnt2); end
        n_cmp++; if (err_pulse2 !== 1'b1) begin n_bad++; $display("FAIL sat_err_pulse5 got=%0b exp=1", err_pulse2); end
`ifdef LANE_FOLLOW_CAPTURE_EN
        n_cmp++; if (err_snap2 !== 16'h0100) begin n_bad++; $display("FAIL snap_kept got=%h exp=0100", err_snap2); end
`endif
        l2.lane_inputs  = 8'h06;
        l2.lane_outputs = 8'h06;
        tick();
        n_cmp++; if (err_pulse2 !== 1'b0) begin n_bad++; $display("FAIL lat0_pass_err_pulse got=%0b exp=0", err_pulse2); end
        n_cmp++; if (pass_cnt2 !== 2'd1) begin n_bad++; $display("FAIL lat0_pass_cnt got=%0d exp=1", pass_cnt2); end
        l2.lane_inputs = 8'h07;
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        n_cmp++; if (err_cnt2 !== 2'd0) begin n_bad++; $display("FAIL clr_over_inc got=%0d exp=0", err_cnt2); end
        n_cmp++; if (err_pulse2 !== 1'b1) begin n_bad++; $display("FAIL clr_err_pulse got=%0b exp=1", err_pulse2); end
        n_cmp++; if (pass_cnt2 !== 2'd0) begin n_bad++; $display("FAIL clr_pass_cnt2 got=%0d exp=0", pass_cnt2); end
`ifdef LANE_FOLLOW_CAPTURE_EN
        n_cmp++; if (snap_vld2 !== 1'b0) begin n_bad++; $display("FAIL snap_vld_clr got=%0b exp=0", snap_vld2); end
`endif
        tick();
        n_cmp++; if (err_pulse2 !== 1'b0) begin n_bad++; $display("FAIL post_clr_err_pulse got=%0b exp=0", err_pulse2); end
        n_cmp++; if (err_cnt2 !== 2'd0) begin n_bad++; $display("FAIL post_clr_err_cnt got=%0d exp=0", err_cnt2); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        ana_byp = 1'b1;
        clr = 1'b0;
        ana_byp2 = 1'b1;
        clr2 = 1'b0;
        l1.lane_inputs  = 8'hA5;
        l1.lane_outputs = 8'h00;
        l2.lane_inputs  = 8'h00;
        l2.lane_outputs = 8'h00;

        test_reset();
        test_bypass_resync();
        test_pass();
        test_same_cycle();
        test_timeout();
        test_retrigger();
        test_abandon();
        test_clr();
        test_saturate_lat0();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lane_follow_monitor.md
Name: lane_follow_monitor

Overview:
- Synthesizable run-time checker that enforces "lane inputs change implies lane outputs change" in hardware, not only in simulation.
- Sits directly downstream of the lane mux/driver and taps its lane_inputs and lane_outputs buses.
- Checking is active only while ana_byp is 1; it is disabled when ana_byp is 0.
- Reports a per-violation pulse plus saturating pass and error counters for the debug register block.

Parameters:
- LANES, 8, width of the lane_inputs and lane_outputs buses.
- MAX_LAT, 2, allowed cycles from an input change to an output change; 0 means the same cycle.
- CNT_W, 16, width of the pass and error counters.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- ana_byp  in  1  check enable; 0 disables checking and abandons any pending check.
- lane_inputs  in  LANES  monitored lane inputs.
- lane_outputs  in  LANES  monitored lane outputs.
- clr  in  1  synchronous clear of both counters.
- pending  out  1  high while an input change is awaiting an output change.
- err_pulse  out  1  one-cycle pulse per violation.
- pass_cnt  out  CNT_W  saturating count of satisfied checks.
- err_cnt  out  CNT_W  saturating count of violations.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, in_q and out_q cleared, prime flag cleared.
- Change detect:
  - in_chg = (lane_inputs != in_q); out_chg = (lane_outputs != out_q).
  - in_q and out_q update every cycle, including when ana_byp is 0.
  - in_chg and out_chg are forced to 0 in the first cycle after reset release; the prime flag sets after that cycle.
- States: IDLE, WAIT, OFF.
- OFF:
  - Entered from any state in the cycle after ana_byp is sampled 0.
  - pending = 0; no counts, no errors.
  - When ana_byp is sampled 1, go to IDLE. Checking starts that same cycle against the tracked in_q/out_q, with no stale history.
- IDLE, ana_byp = 1:
  - in_chg and out_chg both high: pass_cnt++, stay in IDLE.
  - in_chg high, out_chg low, MAX_LAT = 0: err_pulse next cycle, err_cnt++.
  - in_chg high, out_chg low, MAX_LAT > 0: go to WAIT, timer = MAX_LAT, pending = 1.
  - out_chg alone is ignored.
- WAIT:
  - out_chg: pass_cnt++, go to IDLE. This takes priority over a simultaneous in_chg and over timer expiry.
  - in_chg without out_chg: reload timer to MAX_LAT (retrigger, coalesced); no count.
  - timer reaches 0 with no out_chg: err_pulse, err_cnt++, go to IDLE.
  - timer decrements once per cycle otherwise.
- Latency: err_pulse and counter updates are registered, 1 cycle after the deciding sample.
- Counters: saturate at all-ones, never wrap.
- clr: zeroes both counters next cycle and overrides an increment in the same cycle. err_pulse and state are unaffected.
- ana_byp falling mid-WAIT: the check is abandoned silently; no error, no pass.

Optional Feature:
- Macro: LANE_FOLLOW_CAPTURE_EN.
- With the macro:
  - Adds output err_snap [2*LANES] and output snap_vld.
  - On the first violation since reset or clr, latch {lane_inputs at the triggering change, out_q at expiry} and set snap_vld.
  - Later errors do not overwrite the snapshot.
  - clr clears snap_vld.
- Without the macro: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package lane_follow_pkg:
  - state enum lf_state_e {LF_IDLE, LF_WAIT, LF_OFF}.
  - Timer width function clog2(MAX_LAT+1), minimum 1.
  - Counter saturation helper function.
- Sub-module lane_chg_det:
  - Registered previous-value compare with prime-flag suppression, parameterized by width.
  - Instantiated twice, for inputs and for outputs.

Test Plan:
- Reset release with lane_inputs=8'hA5 static, ana_byp=1 -> no in_chg in the first cycle, counters 0, pending 0.
- MAX_LAT=2, inputs 00->01 at cycle 10, outputs 00->01 at cycle 11 -> pass_cnt=1, err_cnt=0, pending high for 1 cycle.
- MAX_LAT=2, inputs change at cycle 10, outputs static -> err_pulse at cycle 13, err_cnt=1, back to IDLE.
- WAIT retrigger: inputs change at cycles 10 and 11, outputs change at 13 -> pass_cnt=1, no error.
- ana_byp dropped at cycle 11 during WAIT, outputs never change -> no err_pulse; pending 0 from cycle 12.
- CNT_W=2, 5 violations -> err_cnt=3 (saturated); clr asserted together with a 6th violation -> err_cnt=0. With LANE_FOLLOW_CAPTURE_EN, err_snap holds the first violation's values and snap_vld=0 after clr.
